lcd_frame_arbiter: RTL and testbench

Shared character-frame controller for the 16x2 LCD path. It owns the 32-character display frame and drives the flattened `chars` bus consumed by the LCD driver. Two independent requesters write single characters through a req/ack handshake under round-robin arbitration. A clear command sweeps the frame back to a fill character.

---
 rtl/lcd_frame_arbiter.sv | 116 +++++++++++
 tb/tb_lcd_frame_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_arbiter.sv
// 32-character LCD frame with two round-robin arbitrated single-character writers
// and a one-position-per-cycle clear sweep.
module lcd_frame_arbiter #(
    parameter logic [7:0] CLR_CHAR = 8'h20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [4:0]   pos0,
    input  logic [7:0]   data0,
    output logic         ack0,
    input  logic         req1,
    input  logic [4:0]   pos1,
    input  logic [7:0]   data1,
    output logic         ack1,
    input  logic         clr,
    output logic         busy,
    output logic [255:0] chars,
    output logic         upd
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state_reg, state_next;
    logic [4:0] idx_reg;
    logic       ack0_reg, ack1_reg, upd_reg;
    logic       last_reg;
    logic       grant0, grant1, clear_we;
    logic       elig0, elig1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (clr) state_next = CLEAR;
            CLEAR:   if (idx_reg == 5'd31) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A requester whose ack is still high is releasing req and must not win again.
    assign elig0 = req0 && !ack0_reg;
    assign elig1 = req1 && !ack1_reg;

    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        clear_we = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!clr) begin
                    grant0 = elig0 && (!elig1 || last_reg);
                    grant1 = elig1 && (!elig0 || !last_reg);
                end
            end
            CLEAR:   clear_we = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg  <= 5'd0;
            ack0_reg <= 1'b0;
            ack1_reg <= 1'b0;
            upd_reg  <= 1'b0;
            last_reg <= 1'b1;
        end else begin
            ack0_reg <= grant0;
            ack1_reg <= grant1;
            // The whole sweep counts as a single frame change, signalled once at its end.
            upd_reg  <= grant0 || grant1 || (clear_we && idx_reg == 5'd31);
            if (grant0) begin
                last_reg <= 1'b0;
            end else if (grant1) begin
                last_reg <= 1'b1;
            end
            idx_reg  <= clear_we ? idx_reg + 5'd1 : 5'd0;
        end
    end

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_cell
            localparam logic [4:0] POS = 5'(gi);
            logic [7:0] cell_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cell_reg <= CLR_CHAR;
                end else if (clear_we && idx_reg == POS) begin
                    cell_reg <= CLR_CHAR;
                end else if (grant0 && pos0 == POS) begin
                    cell_reg <= data0;
                end else if (grant1 && pos1 == POS) begin
                    cell_reg <= data1;
                end
            end

            // Position 0 sits in the top byte so the bus reads left-to-right, top row first.
            assign chars[255 - 8*gi -: 8] = cell_reg;
        end
    endgenerate

    assign ack0 = ack0_reg;
    assign ack1 = ack1_reg;
    assign upd  = upd_reg;
    assign busy = (state_reg == CLEAR);

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Self-checking bench for lcd_frame_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the frame.
module tb_lcd_frame_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0, clr = 1'b0;
    logic [4:0]   pos0 = 5'd0, pos1 = 5'd0;
    logic [7:0]   data0 = 8'd0, data1 = 8'd0;
    logic         ack0, ack1, busy, upd;
    logic [255:0] chars;

    int checks = 0;
    int passed = 0;

    logic [255:0] all_clr = {32{8'h20}};

    always #5 clk = ~clk;

    lcd_frame_arbiter #(.CLR_CHAR(8'h20)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .pos0(pos0), .data0(data0), .ack0(ack0),
        .req1(req1), .pos1(pos1), .data1(data1), .ack1(ack1),
        .clr(clr), .busy(busy), .chars(chars), .upd(upd)
    );

    // Behavioural model: frame as a byte array, clear as a remaining-count.
    logic [7:0] m_frame [32];
    logic       m_ack0, m_ack1, m_upd, m_busy, m_last;
    int         m_clear_left, m_clear_idx;

    function automatic logic [255:0] m_chars();
        logic [255:0] v;
        for (int p = 0; p < 32; p++) v[255 - 8*p -: 8] = m_frame[p];
        return v;
    endfunction

    function automatic logic [7:0] byte_at(input logic [255:0] bus, input int p);
        return bus[255 - 8*p -: 8];
    endfunction

    task automatic model_edge();
        logic e0, e1, g0, g1;
        if (rst) begin
            for (int p = 0; p < 32; p++) m_frame[p] = 8'h20;
            m_ack0 = 0; m_ack1 = 0; m_upd = 0; m_busy = 0; m_last = 1;
            m_clear_left = 0; m_clear_idx = 0;
        end else if (m_clear_left > 0) begin
            m_frame[m_clear_idx] = 8'h20;
            m_clear_idx++;
            m_clear_left--;
            m_ack0 = 0; m_ack1 = 0;
            m_upd  = (m_clear_left == 0);
            m_busy = (m_clear_left > 0);
        end else if (clr) begin
            m_clear_left = 32; m_clear_idx = 0;
            m_busy = 1; m_ack0 = 0; m_ack1 = 0; m_upd = 0;
        end else begin
            e0 = req0 && !m_ack0;
            e1 = req1 && !m_ack1;
            g0 = e0 && (!e1 || m_last);
            g1 = e1 && !g0;
            if (g0) begin m_frame[pos0] = data0; m_last = 0; end
            if (g1) begin m_frame[pos1] = data1; m_last = 1; end
            m_ack0 = g0; m_ack1 = g1; m_upd = g0 || g1; m_busy = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req0 = 0; req1 = 0; clr = 0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (chars !== all_clr) $display("FAIL reset_chars: got %h expected %h", chars, all_clr); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) $display("FAIL reset_ack: got %b%b expected 00", ack0, ack1); else passed++;
        checks++; if (upd !== 1'b0) $display("FAIL reset_upd: got %b expected 0", upd); else passed++;
        $display("reset: chars=%h busy=%b", chars, busy);
    endtask

    task automatic test_single_write();
        req0 = 1; pos0 = 5'd0; data0 = 8'h48;
        step();
        checks++; if (ack0 !== 1'b1 || upd !== 1'b1) $display("FAIL single_ack_upd: got ack0=%b upd=%b expected 1 1", ack0, upd); else passed++;
        checks++; if (chars[255:248] !== 8'h48) $display("FAIL single_data: got %h expected 48", chars[255:248]); else passed++;
        step();
        checks++; if (ack0 !== 1'b0 || upd !== 1'b0) $display("FAIL single_no_double: got ack0=%b upd=%b expected 0 0", ack0, upd); else passed++;
        req0 = 0;
        step();
        checks++; if (ack0 !== 1'b0) $display("FAIL single_release: got ack0=%b expected 0", ack0); else passed++;
        $display("single write: pos0=0 data=48 chars[255:248]=%h", chars[255:248]);
    endtask

    task automatic test_contention();
        apply_reset();
        req0 = 1; pos0 = 5'd16; data0 = 8'h30;
        req1 = 1; pos1 = 5'd17; data1 = 8'h35;
        step();
        checks++; if (ack0 !== 1'b1 || ack1 !== 1'b0) $display("FAIL contention_first: got ack0=%b ack1=%b expected 1 0", ack0, ack1); else passed++;
        step();
        checks++; if (ack0 !== 1'b0 || ack1 !== 1'b1) $display("FAIL contention_second: got ack0=%b ack1=%b expected 0 1", ack0, ack1); else passed++;
        req0 = 0; req1 = 0;
        step();
        checks++; if (chars[127:120] !== 8'h30) $display("FAIL contention_pos16: got %h expected 30", chars[127:120]); else passed++;
        checks++; if (chars[119:112] !== 8'h35) $display("FAIL contention_pos17: got %h expected 35", chars[119:112]); else passed++;
        $display("contention: pos16=%h pos17=%h", chars[127:120], chars[119:112]);
    endtask

    task automatic test_round_robin();
        logic exp0;
        apply_reset();
        req0 = 1; req1 = 1;
        for (int i = 0; i < 8; i++) begin
            pos0 = 5'($urandom_range(0, 31)); data0 = 8'($urandom);
            pos1 = 5'($urandom_range(0, 31)); data1 = 8'($urandom);
            step();
            exp0 = (i % 2 == 0);
            checks++; if (ack0 !== exp0 || ack1 !== !exp0) $display("FAIL rr_cycle%0d: got ack0=%b ack1=%b expected %b %b", i, ack0, ack1, exp0, !exp0); else passed++;
            checks++; if (chars !== m_chars()) $display("FAIL rr_chars%0d: got %h expected %h", i, chars, m_chars()); else passed++;
            $display("round robin cycle %0d: ack0=%b ack1=%b", i, ack0, ack1);
        end
        req0 = 0; req1 = 0;
        step();
    endtask

    task automatic test_clear();
        int busy_cycles;
        logic saw_ack1;
        for (int i = 0; i < 40; i++) begin
            req0 = 1'($urandom); pos0 = 5'($urandom); data0 = 8'($urandom);
            req1 = 1'($urandom); pos1 = 5'($urandom); data1 = 8'($urandom);
            step();
            checks++; if (chars !== m_chars()) $display("FAIL fill_chars%0d: got %h expected %h", i, chars, m_chars()); else passed++;
        end
        req0 = 0; req1 = 0;
        step();
        clr = 1; req1 = 1; pos1 = 5'd5; data1 = 8'h77;
        step();
        clr = 0;
        busy_cycles = 0;
        saw_ack1 = 0;
        for (int n = 0; n < 40; n++) begin
            if (!busy) break;
            busy_cycles++;
            if (ack1) saw_ack1 = 1;
            step();
        end
        checks++; if (busy !== 1'b0) $display("FAIL clear_timeout: got busy=%b expected 0 within 40 cycles", busy); else passed++;
        checks++; if (busy_cycles != 32) $display("FAIL clear_busy_len: got %0d expected 32", busy_cycles); else passed++;
        checks++; if (saw_ack1 !== 1'b0) $display("FAIL clear_ack_during: got %b expected 0", saw_ack1); else passed++;
        checks++; if (upd !== 1'b1) $display("FAIL clear_upd: got %b expected 1", upd); else passed++;
        checks++; if (chars !== all_clr) $display("FAIL clear_chars: got %h expected %h", chars, all_clr); else passed++;
        $display("clear: busy_cycles=%0d upd=%b", busy_cycles, upd);
        step();
        checks++; if (ack1 !== 1'b1) $display("FAIL clear_ack1_after: got %b expected 1", ack1); else passed++;
        checks++; if (byte_at(chars, 5) !== 8'h77) $display("FAIL clear_write_after: got %h expected 77", byte_at(chars, 5)); else passed++;
        req1 = 0;
        step();
        $display("post-clear write: ack1 served, pos5=%h", byte_at(chars, 5));
    endtask

    task automatic test_reset_mid_clear();
        req0 = 1; pos0 = 5'd30; data0 = 8'h41;
        step();
        req0 = 0;
        step();
        clr = 1;
        step();
        clr = 0;
        for (int i = 1; i < 10; i++) step();
        checks++; if (busy !== 1'b1) $display("FAIL midclr_busy_before: got %b expected 1", busy); else passed++;
        rst = 1;
        step();
        rst = 0;
        checks++; if (busy !== 1'b0) $display("FAIL midclr_busy: got %b expected 0", busy); else passed++;
        checks++; if (upd !== 1'b0) $display("FAIL midclr_upd: got %b expected 0", upd); else passed++;
        checks++; if (chars !== all_clr) $display("FAIL midclr_chars: got %h expected %h", chars, all_clr); else passed++;
        step();
        checks++; if (upd !== 1'b0 || busy !== 1'b0) $display("FAIL midclr_after: got upd=%b busy=%b expected 0 0", upd, busy); else passed++;
        $display("reset mid-clear: busy=%b chars=%h", busy, chars);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            clr  = ($urandom_range(0, 24) == 0);
            req0 = 1'($urandom); pos0 = 5'($urandom); data0 = 8'($urandom);
            req1 = 1'($urandom); pos1 = 5'($urandom); data1 = 8'($urandom);
            step();
            checks++; if (chars !== m_chars()) $display("FAIL rand_chars%0d: got %h expected %h", i, chars, m_chars()); else passed++;
            checks++; if ({ack0, ack1, upd, busy} !== {m_ack0, m_ack1, m_upd, m_busy})
                $display("FAIL rand_ctrl%0d: got ack0/ack1/upd/busy=%b expected %b", i, {ack0, ack1, upd, busy}, {m_ack0, m_ack1, m_upd, m_busy});
            else passed++;
        end
        rst = 0; clr = 0; req0 = 0; req1 = 0;
        $display("random: 300 cycles compared against model");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_round_robin();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
